// File: rtl/ula_serial_ctrl.sv
// Bit-serial ALU controller: feeds operand bits LSB-first to an external 1-bit slice and collects the result.
// Optional flag registers are enabled with macro ULA_SERIAL_FLAGS_EN.
module ula_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_func,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             slice_a,
  output logic             slice_b,
  output logic [2:0]       slice_func,
  output logic             slice_cin,
  output logic             slice_cin_comp,
  input  logic             slice_r,
  input  logic             slice_cout,
  input  logic             slice_cout_comp
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_shift_reg, b_shift_reg, r_shift_reg, result_reg;
  logic [2:0]       func_reg;
  logic [CW-1:0]    cnt_reg;
  logic             cout_reg, cout_comp_reg;
  logic             accept, in_run, last_bit;
  logic [WIDTH-1:0] r_shift_next;

  assign accept       = (state_reg == IDLE) && start;
  assign in_run       = (state_reg == RUN);
  assign last_bit     = in_run && (cnt_reg == CW'(WIDTH - 1));
  assign r_shift_next = {slice_r, r_shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == CW'(WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit 0 starts the carry chains fresh; later bits take the carries registered from the previous bit.
  always_comb begin
    busy           = (state_reg == RUN);
    done           = (state_reg == DONE);
    slice_a        = 1'b0;
    slice_b        = 1'b0;
    slice_cin      = 1'b0;
    slice_cin_comp = 1'b0;
    if (state_reg == RUN) begin
      slice_a = a_shift_reg[0];
      slice_b = b_shift_reg[0];
      if (cnt_reg == '0) begin
        slice_cin      = 1'b0;
        slice_cin_comp = (func_reg == FUNC_SUB);
      end else begin
        slice_cin      = cout_reg;
        slice_cin_comp = cout_comp_reg;
      end
    end
  end

  assign slice_func = func_reg;
  assign result     = result_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_shift_reg   <= '0;
      b_shift_reg   <= '0;
      r_shift_reg   <= '0;
      result_reg    <= '0;
      func_reg      <= '0;
      cnt_reg       <= '0;
      cout_reg      <= 1'b0;
      cout_comp_reg <= 1'b0;
    end else if (accept) begin
      a_shift_reg <= op_a;
      b_shift_reg <= op_b;
      func_reg    <= op_func;
      cnt_reg     <= '0;
    end else if (in_run) begin
      a_shift_reg   <= a_shift_reg >> 1;
      b_shift_reg   <= b_shift_reg >> 1;
      r_shift_reg   <= r_shift_next;
      cout_reg      <= slice_cout;
      cout_comp_reg <= slice_cout_comp;
      cnt_reg       <= cnt_reg + 1'b1;
      if (last_bit) begin
        result_reg <= r_shift_next;
      end
    end
  end

`ifdef ULA_SERIAL_FLAGS_EN
  logic carry_reg, zero_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (last_bit) begin
      carry_reg <= ((func_reg == FUNC_ADD) || (func_reg == FUNC_SUB)) && slice_cout;
      zero_reg  <= (r_shift_next == '0);
    end
  end

  assign carry_flag = carry_reg;
  assign zero_flag  = zero_reg;
`else
  assign carry_flag = 1'b0;
  assign zero_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Directed bench for ula_serial_ctrl (WIDTH=8) with a behavioural 1-bit slice model.
module tb_ula_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [2:0]   op_func = '0;
  logic         busy, done, carry_flag, zero_flag;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_cin_comp;
  logic [2:0]   slice_func;
  logic         slice_r, slice_cout, slice_cout_comp;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ula_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_func(op_func),
    .busy(busy), .done(done), .result(result), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .slice_a(slice_a), .slice_b(slice_b), .slice_func(slice_func), .slice_cin(slice_cin),
    .slice_cin_comp(slice_cin_comp), .slice_r(slice_r), .slice_cout(slice_cout),
    .slice_cout_comp(slice_cout_comp)
  );

  // External slice: sum chain uses cin/cout, subtract chain adds ~B with cin_comp/cout_comp.
  always_comb begin
    slice_cout      = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
    slice_cout_comp = (slice_a & ~slice_b) | (slice_a & slice_cin_comp) | (~slice_b & slice_cin_comp);
    case (slice_func)
      3'b000:  slice_r = slice_a ^ slice_b ^ slice_cin;
      3'b001:  slice_r = slice_a ^ ~slice_b ^ slice_cin_comp;
      3'b010:  slice_r = slice_a & slice_b;
      3'b011:  slice_r = slice_a | slice_b;
      3'b100:  slice_r = ~(slice_a ^ slice_b);
      3'b101:  slice_r = ~slice_a;
      3'b110:  slice_r = slice_a;
      default: slice_r = ~slice_b;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       chk_c;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller sits at a negedge; start is accepted at the next rising edge.
  task automatic run_op(input vec_t v, input int idx);
    int         busy_cnt;
    int         done_cnt;
    int         done_at;
    logic [7:0] res_s;
    logic       c_s, z_s, exp_c, exp_z;
    busy_cnt = 0; done_cnt = 0; done_at = -1; res_s = '0; c_s = 1'b0; z_s = 1'b0;
`ifdef ULA_SERIAL_FLAGS_EN
    exp_c = v.c; exp_z = v.z;
`else
    exp_c = 1'b0; exp_z = 1'b0;
`endif
    op_a = v.a; op_b = v.b; op_func = v.f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d bit0 slice_a", idx), 32'(slice_a), 32'(v.a[0]));
    chk($sformatf("v%0d bit0 slice_b", idx), 32'(slice_b), 32'(v.b[0]));
    chk($sformatf("v%0d bit0 cin", idx), 32'(slice_cin), 32'd0);
    chk($sformatf("v%0d bit0 cin_comp", idx), 32'(slice_cin_comp), 32'(v.f == 3'b001));
    chk($sformatf("v%0d slice_func", idx), 32'(slice_func), 32'(v.f));
    op_a = 8'($urandom); op_b = 8'($urandom); op_func = 3'($urandom);
    for (int i = 0; i < 14; i++) begin
      if (i == 1) chk($sformatf("v%0d bit1 slice_a", idx), 32'(slice_a), 32'(v.a[1]));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i; res_s = result; c_s = carry_flag; z_s = zero_flag;
        end
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d busy cycles", idx), 32'(busy_cnt), 32'd8);
    chk($sformatf("v%0d done count", idx), 32'(done_cnt), 32'd1);
    chk($sformatf("v%0d done cycle", idx), 32'(done_at), 32'd8);
    chk($sformatf("v%0d result", idx), 32'(res_s), 32'(v.r));
    if (v.chk_c) chk($sformatf("v%0d carry", idx), 32'(c_s), 32'(exp_c));
    chk($sformatf("v%0d zero", idx), 32'(z_s), 32'(exp_z));
    chk($sformatf("v%0d result held", idx), 32'(result), 32'(v.r));
    chk($sformatf("v%0d idle slice bits", idx),
        32'({slice_a, slice_b, slice_cin, slice_cin_comp}), 32'd0);
    $display("op %0d: a=%02h b=%02h f=%0d -> result=%02h carry=%0b zero=%0b done_at=%0d",
             idx, v.a, v.b, v.f, res_s, c_s, z_s, done_at);
  endtask

  initial begin
    vecs[0]  = '{8'h3C, 8'h05, 3'b000, 8'h41, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{8'h05, 8'h05, 3'b001, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h0F, 8'hF0, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'hA5, 8'h0F, 3'b100, 8'h55, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h0F, 8'h33, 3'b101, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h81, 8'h7E, 3'b110, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'h12, 8'hFF, 3'b111, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8'h10, 8'h20, 3'b001, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1, 1'b1};

    // Reset state, including a rising edge while reset is held.
    @(posedge clk); #1;
    chk("reset outputs", 32'({busy, done, carry_flag, zero_flag, slice_a, slice_b,
                              slice_cin, slice_cin_comp}), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset slice_func", 32'(slice_func), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 11; k++) run_op(vecs[k], k);

    // Start held high: accepts only from IDLE, one done every 10 cycles.
    begin
      int dn_cnt, bz_cnt, viol, last_dn, gap_bad;
      logic prev_done;
      dn_cnt = 0; bz_cnt = 0; viol = 0; last_dn = -1; gap_bad = 0; prev_done = 1'b0;
      op_a = 8'h3C; op_b = 8'h05; op_func = 3'b000; start = 1'b1;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (busy) bz_cnt++;
        if (prev_done && busy) viol++;
        if (done) begin
          if (last_dn >= 0 && (j - last_dn) != 10) gap_bad++;
          last_dn = j;
          dn_cnt++;
        end
        prev_done = done;
      end
      start = 1'b0;
      chk("held start done count", 32'(dn_cnt), 32'd4);
      chk("held start busy cycles", 32'(bz_cnt), 32'd32);
      chk("held start accept in DONE", 32'(viol), 32'd0);
      chk("held start done spacing", 32'(gap_bad), 32'd0);
      chk("held start result", 32'(result), 32'h41);
      $display("held start: dones=%0d busy_cycles=%0d result=%02h", dn_cnt, bz_cnt, result);
      repeat (3) @(negedge clk);
    end

    // Asynchronous reset mid-RUN at bit 4 discards the operation.
    begin
      int dn_cnt, bz_cnt;
      dn_cnt = 0; bz_cnt = 0;
      op_a = 8'hFF; op_b = 8'h01; op_func = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre-reset busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid-run reset busy", 32'(busy), 32'd0);
      chk("mid-run reset result", 32'(result), 32'd0);
      chk("mid-run reset slice bits", 32'({slice_a, slice_b, slice_cin, slice_cin_comp}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 12; j++) begin
        if (done) dn_cnt++;
        if (busy) bz_cnt++;
        @(negedge clk);
      end
      chk("post-reset no done", 32'(dn_cnt), 32'd0);
      chk("post-reset no busy", 32'(bz_cnt), 32'd0);
      $display("mid-run reset: busy=%0b result=%02h dones_after=%0d", busy, result, dn_cnt);
      run_op('{8'h0F, 8'h00, 3'b101, 8'hF0, 1'b0, 1'b0, 1'b1}, 11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
